// File: rtl/flash_audio_streamer.sv
// Streams packed audio samples out of a word-addressed flash region, one sample per tick,
// with forward/backward playback, pause, restart and underrun/wrap reporting.
module flash_audio_streamer #(
    parameter int                ADDR_W     = 23,
    parameter int                SAMPLE_W   = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = 23'h0,
    parameter logic [ADDR_W-1:0] END_ADDR   = 23'h7FFFF
) (
    input  logic                clk50M,
    input  logic                reset,
    input  logic                sample_tick,
    input  logic                play,
    input  logic                dir,
    input  logic                restart,
    output logic                flash_mem_read,
    input  logic                flash_mem_waitrequest,
    input  logic                flash_mem_readdatavalid,
    input  logic [31:0]         flash_mem_readdata,
    output logic [ADDR_W-1:0]   flash_mem_address,
    output logic [SAMPLE_W-1:0] audio_out,
    output logic                audio_valid,
    output logic                underrun,
    output logic                wrap
);

    // state    | meaning
    // IDLE     | paused with no buffered word, waiting for play
    // REQ      | read request on the bus, waiting for waitrequest to drop
    // WAITDATA | request accepted, waiting for readdatavalid
    // PLAY     | word buffered, emitting one lane per tick
    typedef enum logic [1:0] {IDLE, REQ, WAITDATA, PLAY} state_t;

    localparam int         N        = 32 / SAMPLE_W;
    localparam logic [1:0] LAST_IDX = 2'(N - 1);

    state_t              state_q;
    logic                read_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         word_q;
    logic                word_dir_q;
    logic [1:0]          idx_q;
    logic                pending_q;
    logic [SAMPLE_W-1:0] audio_q;
    logic                audio_valid_q;
    logic                underrun_q;
    logic                wrap_q;

    logic [1:0]          lane_d;
    logic [SAMPLE_W-1:0] sample_d;
    logic [ADDR_W-1:0]   next_addr_d;
    logic                at_wrap_d;
    logic [ADDR_W-1:0]   restart_addr_d;

    always_comb begin
        lane_d         = word_dir_q ? (LAST_IDX - idx_q) : idx_q;
        sample_d       = SAMPLE_W'(word_q >> (32'(lane_d) * SAMPLE_W));
        restart_addr_d = dir ? END_ADDR : START_ADDR;
        // Advance follows the direction the finished word was played in.
        if (!word_dir_q) begin
            at_wrap_d   = (addr_q == END_ADDR);
            next_addr_d = at_wrap_d ? START_ADDR : addr_q + ADDR_W'(1);
        end else begin
            at_wrap_d   = (addr_q == START_ADDR);
            next_addr_d = at_wrap_d ? END_ADDR : addr_q - ADDR_W'(1);
        end
    end

    always_ff @(posedge clk50M) begin
        if (reset) begin
            state_q       <= IDLE;
            read_q        <= 1'b0;
            addr_q        <= START_ADDR;
            word_q        <= '0;
            word_dir_q    <= 1'b0;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            audio_q       <= '0;
            audio_valid_q <= 1'b0;
            underrun_q    <= 1'b0;
            wrap_q        <= 1'b0;
        end else begin
            audio_valid_q <= 1'b0;
            underrun_q    <= 1'b0;
            wrap_q        <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (restart) addr_q <= restart_addr_d;
                    if (play) begin
                        state_q <= REQ;
                        read_q  <= 1'b1;
                    end
                end
                REQ: begin
                    if (restart) pending_q <= 1'b1;
                    else if (sample_tick && play) underrun_q <= 1'b1;
                    if (!flash_mem_waitrequest) begin
                        state_q <= WAITDATA;
                        read_q  <= 1'b0;
                    end
                end
                WAITDATA: begin
                    if (!restart && sample_tick && play) underrun_q <= 1'b1;
                    if (flash_mem_readdatavalid) begin
                        if (restart || pending_q) begin
                            pending_q <= 1'b0;
                            addr_q    <= restart_addr_d;
                            state_q   <= play ? REQ : IDLE;
                            read_q    <= play;
                        end else begin
                            word_q     <= flash_mem_readdata;
                            word_dir_q <= dir;
                            idx_q      <= '0;
                            state_q    <= PLAY;
                        end
                    end else if (restart) begin
                        pending_q <= 1'b1;
                    end
                end
                PLAY: begin
                    if (restart) begin
                        addr_q  <= restart_addr_d;
                        idx_q   <= '0;
                        state_q <= play ? REQ : IDLE;
                        read_q  <= play;
                    end else if (sample_tick && play) begin
                        audio_q       <= sample_d;
                        audio_valid_q <= 1'b1;
                        if (idx_q == LAST_IDX) begin
                            addr_q  <= next_addr_d;
                            wrap_q  <= at_wrap_d;
                            idx_q   <= '0;
                            state_q <= REQ;
                            read_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign flash_mem_read    = read_q;
    assign flash_mem_address = addr_q;
    assign audio_out         = audio_q;
    assign audio_valid       = audio_valid_q;
    assign underrun          = underrun_q;
    assign wrap              = wrap_q;

endmodule

// File: tb/tb_flash_audio_streamer.sv
// Directed bench: 8-bit and 16-bit sample instances share stimulus; the idle one is held in reset.
module tb_flash_audio_streamer;

    logic        clk50M = 1'b0;
    logic        reset8 = 1'b1;
    logic        reset16 = 1'b1;
    logic        sample_tick = 1'b0;
    logic        play = 1'b0;
    logic        dir = 1'b0;
    logic        restart = 1'b0;
    logic        waitreq = 1'b0;
    logic        rdv = 1'b0;
    logic [31:0] rdata = '0;
    logic        sel16 = 1'b0;

    logic        read8, valid8, underrun8, wrap8;
    logic [22:0] addr8;
    logic [7:0]  out8;
    logic        read16, valid16, underrun16, wrap16;
    logic [22:0] addr16;
    logic [15:0] out16;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 clk50M = ~clk50M;

    flash_audio_streamer #(.ADDR_W(23), .SAMPLE_W(8)) dut8 (
        .clk50M(clk50M), .reset(reset8), .sample_tick(sample_tick), .play(play),
        .dir(dir), .restart(restart), .flash_mem_read(read8),
        .flash_mem_waitrequest(waitreq), .flash_mem_readdatavalid(rdv),
        .flash_mem_readdata(rdata), .flash_mem_address(addr8), .audio_out(out8),
        .audio_valid(valid8), .underrun(underrun8), .wrap(wrap8)
    );

    flash_audio_streamer #(.ADDR_W(23), .SAMPLE_W(16)) dut16 (
        .clk50M(clk50M), .reset(reset16), .sample_tick(sample_tick), .play(play),
        .dir(dir), .restart(restart), .flash_mem_read(read16),
        .flash_mem_waitrequest(waitreq), .flash_mem_readdatavalid(rdv),
        .flash_mem_readdata(rdata), .flash_mem_address(addr16), .audio_out(out16),
        .audio_valid(valid16), .underrun(underrun16), .wrap(wrap16)
    );

    logic        o_read, o_valid, o_underrun, o_wrap;
    logic [31:0] o_addr, o_out;
    assign o_read     = sel16 ? read16 : read8;
    assign o_valid    = sel16 ? valid16 : valid8;
    assign o_underrun = sel16 ? underrun16 : underrun8;
    assign o_wrap     = sel16 ? wrap16 : wrap8;
    assign o_addr     = sel16 ? {9'h0, addr16} : {9'h0, addr8};
    assign o_out      = sel16 ? {16'h0, out16} : {24'h0, out8};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk50M);
        #1;
    endtask

    task automatic load(input logic [31:0] word);
        rdv   = 1'b1;
        rdata = word;
        cyc();
        rdv   = 1'b0;
    endtask

    // Accept the pending request (waitrequest low), then return the word.
    task automatic give_data(input string tag, input logic [31:0] word);
        chk({tag, "_req"}, {31'h0, o_read}, 32'h1);
        cyc();
        load(word);
    endtask

    task automatic do_tick(input string tag, input logic [31:0] exp);
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        chk({tag, "_valid"}, {31'h0, o_valid}, 32'h1);
        chk({tag, "_out"}, o_out, exp);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_read"}, {31'h0, o_read}, 32'h0);
        chk({tag, "_addr"}, o_addr, 32'h0);
        chk({tag, "_out"}, o_out, 32'h0);
        chk({tag, "_valid"}, {31'h0, o_valid}, 32'h0);
        chk({tag, "_underrun"}, {31'h0, o_underrun}, 32'h0);
        chk({tag, "_wrap"}, {31'h0, o_wrap}, 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        repeat (3) cyc();
        chk_reset("rst8");

        // Forward word at address 0
        reset8 = 1'b0;
        play   = 1'b1;
        dir    = 1'b0;
        cyc();
        chk("fwd_addr0", o_addr, 32'h0);
        give_data("fwd", 32'hDDCCBBAA);
        do_tick("fwd0", 32'hAA);
        cyc();
        chk("fwd_valid_drop", {31'h0, o_valid}, 32'h0);
        do_tick("fwd1", 32'hBB);
        do_tick("fwd2", 32'hCC);
        do_tick("fwd3", 32'hDD);
        chk("fwd_next_read", {31'h0, o_read}, 32'h1);
        chk("fwd_next_addr", o_addr, 32'h1);
        chk("fwd_no_wrap", {31'h0, o_wrap}, 32'h0);

        // Stalled request, then a tick while waiting for data
        waitreq = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_read && waitreq) cnt++;
            cyc();
        end
        waitreq = 1'b0;
        chk("stall_read_cycles", cnt, 10);
        cyc();
        chk("stall_read_dropped", {31'h0, o_read}, 32'h0);
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        chk("udr_pulse", {31'h0, o_underrun}, 32'h1);
        chk("udr_no_valid", {31'h0, o_valid}, 32'h0);
        chk("udr_out_held", o_out, 32'hDD);
        cyc();
        chk("udr_drop", {31'h0, o_underrun}, 32'h0);
        load(32'h44332211);
        do_tick("w2_0", 32'h11);

        // Pause freezes output
        play = 1'b0;
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        chk("pause_no_valid", {31'h0, o_valid}, 32'h0);
        chk("pause_out_held", o_out, 32'h11);
        play = 1'b1;
        do_tick("w2_1", 32'h22);
        do_tick("w2_2", 32'h33);
        do_tick("w2_3", 32'h44);
        chk("w2_next_addr", o_addr, 32'h2);

        // Restart during WAITDATA discards the returned word
        cyc();
        dir = 1'b1;
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        load(32'h55555555);
        chk("rst_wd_no_valid", {31'h0, o_valid}, 32'h0);
        chk("rst_wd_addr", o_addr, 32'h7FFFF);
        chk("rst_wd_read", {31'h0, o_read}, 32'h1);

        // Backward word from the end address
        give_data("bwd", 32'hDDCCBBAA);
        do_tick("bwd0", 32'hDD);
        do_tick("bwd1", 32'hCC);
        do_tick("bwd2", 32'hBB);
        do_tick("bwd3", 32'hAA);
        chk("bwd_next_addr", o_addr, 32'h7FFFE);
        chk("bwd_no_wrap", {31'h0, o_wrap}, 32'h0);

        // Restart while in REQ, then forward word at END_ADDR wraps to START_ADDR
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        load(32'h66666666);
        chk("rst_req_no_valid", {31'h0, o_valid}, 32'h0);
        chk("rst_req_addr", o_addr, 32'h7FFFF);
        dir = 1'b0;
        give_data("fwrap", 32'h04030201);
        do_tick("fwrap0", 32'h01);
        do_tick("fwrap1", 32'h02);
        do_tick("fwrap2", 32'h03);
        do_tick("fwrap3", 32'h04);
        chk("fwrap_addr", o_addr, 32'h0);
        chk("fwrap_pulse", {31'h0, o_wrap}, 32'h1);
        cyc();
        chk("fwrap_drop", {31'h0, o_wrap}, 32'h0);

        // Backward word at START_ADDR wraps to END_ADDR
        dir = 1'b1;
        load(32'h08070605);
        do_tick("bwrap0", 32'h08);
        do_tick("bwrap1", 32'h07);
        do_tick("bwrap2", 32'h06);
        do_tick("bwrap3", 32'h05);
        chk("bwrap_addr", o_addr, 32'h7FFFF);
        chk("bwrap_pulse", {31'h0, o_wrap}, 32'h1);

        // Restart and tick together in PLAY: restart wins
        give_data("rt", 32'hDDCCBBAA);
        dir = 1'b0;
        restart = 1'b1;
        sample_tick = 1'b1;
        cyc();
        restart = 1'b0;
        sample_tick = 1'b0;
        chk("rt_no_valid", {31'h0, o_valid}, 32'h0);
        chk("rt_no_underrun", {31'h0, o_underrun}, 32'h0);
        chk("rt_addr", o_addr, 32'h0);
        chk("rt_read", {31'h0, o_read}, 32'h1);

        // 16-bit samples
        reset8 = 1'b1;
        sel16  = 1'b1;
        cyc();
        chk_reset("rst16");
        reset16 = 1'b0;
        dir     = 1'b0;
        cyc();
        give_data("s16", 32'h22221111);
        do_tick("s16_0", 32'h1111);
        do_tick("s16_1", 32'h2222);
        chk("s16_next_addr", o_addr, 32'h1);
        chk("s16_next_read", {31'h0, o_read}, 32'h1);
        give_data("s16b", 32'hBBBBAAAA);
        do_tick("s16b_0", 32'hAAAA);
        reset16 = 1'b1;
        cyc();
        chk_reset("midrst16");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
